wr_mem_noc_pipe: RTL and testbench
==================================

# wr_mem_noc_pipe

Pipelined NoC write engine: turns source write requests into NoC0 store-memory packets (header flit plus payload flits) toward one DRAM tile. It keeps up to MAX_OUTSTANDING writes in flight instead of blocking on each ack. It sits between a DMA/engine front end and the tile's NoC0 router ports. Completion is reported as one done token per store-memory ack, in issue order.

## Interface
- SRC_X, 0: source tile X coordinate placed in the header.
- SRC_Y, 0: source tile Y coordinate.
- DST_DRAM_X, 0: destination DRAM tile X coordinate.
- DST_DRAM_Y, 0: destination DRAM tile Y coordinate.
- FBITS, 0: source fbits placed in the header.
- MAX_OUTSTANDING, 4: in-flight plus unreported writes permitted; range 1..16.
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- wr_mem_noc_req_noc0_val / _data / noc_wr_mem_req_noc0_rdy: out/out/in, 1/NOC_DATA_WIDTH/1. Request flit channel.
- noc_wr_mem_resp_noc0_val / _data / wr_mem_noc_resp_noc0_rdy: in/in/out, 1/NOC_DATA_WIDTH/1. Ack flit channel.
- src_wr_mem_req_val / src_wr_mem_req_entry / wr_mem_src_req_rdy: in/in/out, 1/mem_req_struct/1. Carries the write address and the size in bytes.
- src_wr_mem_req_data_val / _data / _last / _padbytes / wr_mem_src_req_data_rdy: in/in/in/in/out, 1/NOC_DATA_WIDTH/1/NOC_PADBYTES_WIDTH/1. Payload stream.
- wr_req_done / wr_req_done_rdy: out/in, 1/1. Completion token.
- wr_outstanding: out, clog2(MAX_OUTSTANDING+1). Equals issued_cnt + done_cnt.
- wr_idle: out, 1. High when in READY with both counters at 0.
- wr_err: out, 1. Sticky protocol error flag.

## Operation
- FSM states:
  - READY: wr_mem_src_req_rdy = (issued_cnt + done_cnt < MAX_OUTSTANDING). On accept, latch the entry, set flits = ceil(size / NOC_DATA_BYTES) computed with shift plus a remainder test, and go to SEND_HDR.
  - SEND_HDR: drive the header with msg_type STORE_MEM, msg_len = flits, addr, data_size = size, and src/dst coordinates and fbits from parameters. On rdy, issued_cnt++. Go to SEND_PAYLOAD, or to READY if flits == 0.
  - SEND_PAYLOAD: pass the payload through combinationally. val = data_val, data_rdy = noc rdy. Count handshakes. On the final flit go to READY. _last and _padbytes are not used for sequencing.
- The ack channel is always ready (wr_mem_noc_resp_noc0_rdy = 1).
- A valid STORE_MEM_ACK flit decrements issued_cnt and increments done_cnt.
- wr_req_done = (done_cnt != 0). A done handshake decrements done_cnt.
- Simultaneous events:
  - Header send and ack in the same cycle: issued_cnt unchanged, done_cnt +1.
  - Ack and done handshake in the same cycle: done_cnt unchanged.
  - Both counters saturate-check as described under Configuration.
- Caller is responsible for alignment and request breakup.

## Timing
- Reset values: all val/rdy outputs 0, except wr_mem_src_req_rdy = 1 and wr_mem_noc_resp_noc0_rdy = 1 after the first cycle out of reset. wr_req_done 0, wr_outstanding 0, wr_idle 1, wr_err 0, state READY, counters 0.
- Request accept to header val: 1 cycle.
- Header to first payload flit: 0 bubble when data is valid.
- Back-to-back requests: READY costs 1 cycle per request.
- Ack to wr_req_done high: 1 cycle (registered counter).
- Issue is stalled only by the admission limit. It is never stalled by outstanding acks below that limit.
- A mid-packet reset abandons the packet. The NoC side must be reset together with this block.

## Configuration
- WR_MEM_PIPE_ERR_CHK_EN:
  - Defined: these events set wr_err (sticky until rst) and leave the counters unchanged:
    - a response flit whose msg_type is not STORE_MEM_ACK;
    - an ack arriving while issued_cnt == 0.
  - Undefined: every response flit counts as an ack, with no underflow guard, and wr_err is tied to 0.

## Structure
- noc_struct_pkg holds the existing typedefs: mem_req_struct and noc_hdr_flit.
- Add to noc_struct_pkg a wr_pipe_state_e enum (READY, SEND_HDR, SEND_PAYLOAD).
- Sub-module wr_mem_ack_tracker holds issued_cnt, done_cnt, the admission compare, and the error check. The FSM stays in the top module.

## Test plan
- NOC_DATA_WIDTH 512, size 128, noc rdy held high: header msg_len 2, then 2 payload flits. Ack 5 cycles later leads to wr_req_done high 1 cycle after the ack.
- Sizes 65 and 0: msg_len 2 and 0 respectively. The size-0 request sends a header only and still yields one done.
- MAX_OUTSTANDING 4, no acks returned: 4 requests issue and src_req_rdy drops. One ack plus a done handshake re-enables src_req_rdy in the next cycle.
- wr_req_done_rdy held low while 3 acks arrive: done_cnt reaches 3, admission is limited accordingly, and releasing rdy produces 3 consecutive done handshakes.
- Random noc rdy and data_val stalls on a 4-flit write: exactly 4 payload flits are sent, data is unchanged, and no flit is duplicated.
- With WR_MEM_PIPE_ERR_CHK_EN, inject a LOAD_MEM_ACK response: wr_err rises and stays high, counters are unchanged, and it clears only on rst.

Source files
------------

// File: rtl/wr_mem_noc_pipe_pkg.sv
// noc_struct_pkg: shared NoC0 flit/request typedefs plus the write-pipe FSM state enum.
// Also hosts the flit-count and ack-decode helpers used by wr_mem_noc_pipe.
package noc_struct_pkg;

   localparam int NOC_DATA_WIDTH     = 512;
   localparam int NOC_DATA_BYTES     = NOC_DATA_WIDTH / 8;
   localparam int NOC_OFFSET_W       = $clog2(NOC_DATA_BYTES);
   localparam int NOC_PADBYTES_WIDTH = NOC_OFFSET_W;
   localparam int COORD_W            = 8;
   localparam int FBITS_W            = 4;
   localparam int MSG_TYPE_W         = 8;
   localparam int MSG_LEN_W          = 16;
   localparam int MEM_ADDR_W         = 40;
   localparam int MEM_SIZE_W         = 16;
   localparam int HDR_USED_W         = 4*COORD_W + FBITS_W + MSG_TYPE_W + MSG_LEN_W
                                       + MEM_ADDR_W + MEM_SIZE_W;
   localparam int HDR_RSVD_W         = NOC_DATA_WIDTH - HDR_USED_W;

   typedef enum logic [MSG_TYPE_W-1:0] {
      LOAD_MEM      = 8'h02,
      STORE_MEM     = 8'h03,
      LOAD_MEM_ACK  = 8'h12,
      STORE_MEM_ACK = 8'h13
   } noc_msg_type_e;

   typedef struct packed {
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_SIZE_W-1:0] size;
   } mem_req_struct;

   typedef struct packed {
      logic [COORD_W-1:0]    dst_x;
      logic [COORD_W-1:0]    dst_y;
      logic [COORD_W-1:0]    src_x;
      logic [COORD_W-1:0]    src_y;
      logic [FBITS_W-1:0]    fbits;
      noc_msg_type_e         msg_type;
      logic [MSG_LEN_W-1:0]  msg_len;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_SIZE_W-1:0] data_size;
      logic [HDR_RSVD_W-1:0] rsvd;
   } noc_hdr_flit;

   typedef enum logic [1:0] {
      READY,
      SEND_HDR,
      SEND_PAYLOAD
   } wr_pipe_state_e;

   // Ceiling division by the flit size: whole flits plus one if any remainder bytes.
   function automatic logic [MSG_LEN_W-1:0] flit_count(input logic [MEM_SIZE_W-1:0] size);
      return MSG_LEN_W'(size >> NOC_OFFSET_W) + MSG_LEN_W'(|size[NOC_OFFSET_W-1:0]);
   endfunction

   function automatic noc_msg_type_e hdr_msg_type(input logic [NOC_DATA_WIDTH-1:0] flit);
      noc_hdr_flit h;
      h = noc_hdr_flit'(flit);
      return h.msg_type;
   endfunction

endpackage

// File: rtl/wr_mem_noc_pipe_if.sv
// Bundle of source, NoC0 request/ack, and completion signals for wr_mem_noc_pipe.
// master = the write engine, slave = front end plus NoC router side.
interface wr_mem_noc_pipe_if #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
);
   import noc_struct_pkg::*;

   logic                          wr_mem_noc_req_noc0_val;
   logic [NOC_DATA_WIDTH-1:0]     wr_mem_noc_req_noc0_data;
   logic                          noc_wr_mem_req_noc0_rdy;
   logic                          noc_wr_mem_resp_noc0_val;
   logic [NOC_DATA_WIDTH-1:0]     noc_wr_mem_resp_noc0_data;
   logic                          wr_mem_noc_resp_noc0_rdy;
   logic                          src_wr_mem_req_val;
   mem_req_struct                 src_wr_mem_req_entry;
   logic                          wr_mem_src_req_rdy;
   logic                          src_wr_mem_req_data_val;
   logic [NOC_DATA_WIDTH-1:0]     src_wr_mem_req_data;
   logic                          src_wr_mem_req_data_last;
   logic [NOC_PADBYTES_WIDTH-1:0] src_wr_mem_req_data_padbytes;
   logic                          wr_mem_src_req_data_rdy;
   logic                          wr_req_done;
   logic                          wr_req_done_rdy;
   logic [OUT_W-1:0]              wr_outstanding;
   logic                          wr_idle;
   logic                          wr_err;

   modport master (
      output wr_mem_noc_req_noc0_val, wr_mem_noc_req_noc0_data,
      input  noc_wr_mem_req_noc0_rdy,
      input  noc_wr_mem_resp_noc0_val, noc_wr_mem_resp_noc0_data,
      output wr_mem_noc_resp_noc0_rdy,
      input  src_wr_mem_req_val, src_wr_mem_req_entry,
      output wr_mem_src_req_rdy,
      input  src_wr_mem_req_data_val, src_wr_mem_req_data, src_wr_mem_req_data_last,
      input  src_wr_mem_req_data_padbytes,
      output wr_mem_src_req_data_rdy,
      output wr_req_done,
      input  wr_req_done_rdy,
      output wr_outstanding, wr_idle, wr_err
   );

   modport slave (
      input  wr_mem_noc_req_noc0_val, wr_mem_noc_req_noc0_data,
      output noc_wr_mem_req_noc0_rdy,
      output noc_wr_mem_resp_noc0_val, noc_wr_mem_resp_noc0_data,
      input  wr_mem_noc_resp_noc0_rdy,
      output src_wr_mem_req_val, src_wr_mem_req_entry,
      input  wr_mem_src_req_rdy,
      output src_wr_mem_req_data_val, src_wr_mem_req_data, src_wr_mem_req_data_last,
      output src_wr_mem_req_data_padbytes,
      input  wr_mem_src_req_data_rdy,
      input  wr_req_done,
      output wr_req_done_rdy,
      input  wr_outstanding, wr_idle, wr_err
   );

endinterface

// File: rtl/wr_mem_ack_tracker.sv
// Issued/done counters, admission compare and ack protocol check for wr_mem_noc_pipe.
// WR_MEM_PIPE_ERR_CHK_EN enables the sticky wr_err check on bad or unexpected acks.
module wr_mem_ack_tracker
   import noc_struct_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_issue,
   input  logic             i_ack_val,
   input  noc_msg_type_e    i_ack_type,
   input  logic             i_done_rdy,
   output logic             o_admit,
   output logic             o_done,
   output logic             o_cnt_zero,
   output logic [CNT_W-1:0] o_outstanding,
   output logic             o_err
);

   logic [CNT_W-1:0] r_issued;
   logic [CNT_W-1:0] r_done;
   logic             w_ack;
   logic             w_done_fire;

`ifdef WR_MEM_PIPE_ERR_CHK_EN
   logic w_bad_ack;
   logic r_err;

   // A rejected ack leaves both counters alone; only the sticky flag records it.
   assign w_bad_ack = i_ack_val && ((i_ack_type != STORE_MEM_ACK) || (r_issued == '0));
   assign w_ack     = i_ack_val && !w_bad_ack;

   always_ff @(posedge clk) begin
      if (rst)            r_err <= 1'b0;
      else if (w_bad_ack) r_err <= 1'b1;
   end
   assign o_err = r_err;
`else
   logic w_unused_type;

   assign w_unused_type = ^i_ack_type;
   assign w_ack         = i_ack_val;
   assign o_err         = 1'b0;
`endif

   assign w_done_fire = (r_done != '0) && i_done_rdy;

   // NOTE: state registers use non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_issued <= '0;
         r_done   <= '0;
      end else begin
         r_issued <= r_issued + CNT_W'(i_issue) - CNT_W'(w_ack);
         r_done   <= r_done + CNT_W'(w_ack) - CNT_W'(w_done_fire);
      end
   end

   assign o_outstanding = r_issued + r_done;
   assign o_admit       = o_outstanding < CNT_W'(MAX_OUTSTANDING);
   assign o_done        = (r_done != '0);
   assign o_cnt_zero    = (r_issued == '0) && (r_done == '0);

endmodule

// File: rtl/wr_mem_noc_pipe.sv
// Pipelined NoC0 store-memory write engine: header + payload flits, ordered done tokens.
// Optional WR_MEM_PIPE_ERR_CHK_EN adds ack protocol checking inside wr_mem_ack_tracker.
module wr_mem_noc_pipe
   import noc_struct_pkg::*;
#(
   parameter int SRC_X           = 0,
   parameter int SRC_Y           = 0,
   parameter int DST_DRAM_X      = 0,
   parameter int DST_DRAM_Y      = 0,
   parameter int FBITS           = 0,
   parameter int MAX_OUTSTANDING = 4
) (
   input logic               clk,
   input logic               rst,
   wr_mem_noc_pipe_if.master bus
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   wr_pipe_state_e       r_state;
   wr_pipe_state_e       w_state_nxt;
   mem_req_struct        r_req;
   logic [MSG_LEN_W-1:0] r_flits;
   logic [MSG_LEN_W-1:0] r_sent;
   logic                 r_live;
   logic                 w_admit;
   logic                 w_cnt_zero;
   logic                 w_req_fire;
   logic                 w_hdr_fire;
   logic                 w_pay_fire;
   logic                 w_last_flit;
   noc_hdr_flit          w_hdr;

   assign w_req_fire  = bus.src_wr_mem_req_val && bus.wr_mem_src_req_rdy;
   assign w_hdr_fire  = (r_state == SEND_HDR) && bus.noc_wr_mem_req_noc0_rdy;
   assign w_pay_fire  = (r_state == SEND_PAYLOAD) && bus.src_wr_mem_req_data_val
                        && bus.noc_wr_mem_req_noc0_rdy;
   assign w_last_flit = (r_sent == r_flits - MSG_LEN_W'(1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= READY;
      else     r_state <= w_state_nxt;
   end

   // NOTE: each combinational block assigns a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         READY:        if (w_req_fire) w_state_nxt = SEND_HDR;
         SEND_HDR:     if (w_hdr_fire) w_state_nxt = (r_flits == '0) ? READY : SEND_PAYLOAD;
         SEND_PAYLOAD: if (w_pay_fire && w_last_flit) w_state_nxt = READY;
         default:      w_state_nxt = READY;
      endcase
   end

   always_comb begin
      bus.wr_mem_src_req_rdy       = 1'b0;
      bus.wr_mem_noc_req_noc0_val  = 1'b0;
      bus.wr_mem_noc_req_noc0_data = '0;
      bus.wr_mem_src_req_data_rdy  = 1'b0;
      unique case (r_state)
         READY: bus.wr_mem_src_req_rdy = r_live && w_admit;
         SEND_HDR: begin
            bus.wr_mem_noc_req_noc0_val  = 1'b1;
            bus.wr_mem_noc_req_noc0_data = w_hdr;
         end
         SEND_PAYLOAD: begin
            bus.wr_mem_noc_req_noc0_val  = bus.src_wr_mem_req_data_val;
            bus.wr_mem_noc_req_noc0_data = bus.src_wr_mem_req_data;
            bus.wr_mem_src_req_data_rdy  = bus.noc_wr_mem_req_noc0_rdy;
         end
         default: ;
      endcase
   end

   // r_live holds the ready outputs low for the first cycle after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_live  <= 1'b0;
         r_req   <= '0;
         r_flits <= '0;
         r_sent  <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_req_fire) begin
            r_req   <= bus.src_wr_mem_req_entry;
            r_flits <= flit_count(bus.src_wr_mem_req_entry.size);
         end
         if (w_hdr_fire)      r_sent <= '0;
         else if (w_pay_fire) r_sent <= r_sent + MSG_LEN_W'(1);
      end
   end

   always_comb begin
      w_hdr           = '0;
      w_hdr.dst_x     = COORD_W'(DST_DRAM_X);
      w_hdr.dst_y     = COORD_W'(DST_DRAM_Y);
      w_hdr.src_x     = COORD_W'(SRC_X);
      w_hdr.src_y     = COORD_W'(SRC_Y);
      w_hdr.fbits     = FBITS_W'(FBITS);
      w_hdr.msg_type  = STORE_MEM;
      w_hdr.msg_len   = r_flits;
      w_hdr.addr      = r_req.addr;
      w_hdr.data_size = r_req.size;
   end

   assign bus.wr_mem_noc_resp_noc0_rdy = r_live;
   assign bus.wr_idle                  = (r_state == READY) && w_cnt_zero;

   wr_mem_ack_tracker #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W)
   ) u_ack_tracker (
      .clk           (clk),
      .rst           (rst),
      .i_issue       (w_hdr_fire),
      .i_ack_val     (bus.noc_wr_mem_resp_noc0_val && r_live),
      .i_ack_type    (hdr_msg_type(bus.noc_wr_mem_resp_noc0_data)),
      .i_done_rdy    (bus.wr_req_done_rdy),
      .o_admit       (w_admit),
      .o_done        (bus.wr_req_done),
      .o_cnt_zero    (w_cnt_zero),
      .o_outstanding (bus.wr_outstanding),
      .o_err         (bus.wr_err)
   );

endmodule

// File: tb/tb_wr_mem_noc_pipe.sv
// Directed bench for wr_mem_noc_pipe: request flits and done tokens go through scoreboards.
// Error-check steps follow WR_MEM_PIPE_ERR_CHK_EN when it is defined.
`timescale 1ns/1ps
module tb_wr_mem_noc_pipe;
   import noc_struct_pkg::*;

   localparam int MAXO  = 4;
   localparam int CNT_W = $clog2(MAXO + 1);
   localparam int SX = 1, SY = 2, DX = 5, DY = 6, FB = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail = 0;
   int   n_flits_seen = 0;
   int   n_done_hs = 0;
   bit   rand_rdy = 1'b0;
   logic [NOC_DATA_WIDTH-1:0] exp_q[$];
   int   exp_done[$];

   wr_mem_noc_pipe_if #(.MAX_OUTSTANDING(MAXO)) bus();

   wr_mem_noc_pipe #(
      .SRC_X(SX), .SRC_Y(SY), .DST_DRAM_X(DX), .DST_DRAM_Y(DY), .FBITS(FB),
      .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // NoC request ready: held high, or randomised per cycle during the stall test.
   initial begin
      bus.noc_wr_mem_req_noc0_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.noc_wr_mem_req_noc0_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Scoreboard side: compare every request flit and done handshake as they happen.
   always @(negedge clk) begin
      logic [NOC_DATA_WIDTH-1:0] e;
      bit tok;
      if (!rst && bus.wr_mem_noc_req_noc0_val && bus.noc_wr_mem_req_noc0_rdy) begin
         n_flits_seen++;
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
         n_assert++;
         assert (bus.wr_mem_noc_req_noc0_data === e) else begin
            n_fail++;
            $error("FAIL flit: observed %0h expected %0h", bus.wr_mem_noc_req_noc0_data, e);
         end
      end
      if (!rst && bus.wr_req_done && bus.wr_req_done_rdy) begin
         n_done_hs++;
         tok = (exp_done.size() != 0);
         if (tok) void'(exp_done.pop_front());
         n_assert++;
         assert (tok === 1'b1) else begin
            n_fail++;
            $error("FAIL done_token: observed unexpected token, expected none pending");
         end
      end
   end

   task automatic chk(input string tag, input logic [NOC_DATA_WIDTH-1:0] obs,
                      input logic [NOC_DATA_WIDTH-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic send_req(input logic [MEM_ADDR_W-1:0] addr,
                           input logic [MEM_SIZE_W-1:0] size, input bit stall);
      int nf;
      int t;
      noc_hdr_flit h;
      logic [NOC_DATA_WIDTH-1:0] d;
      nf          = (int'(size) + NOC_DATA_BYTES - 1) / NOC_DATA_BYTES;
      h           = '0;
      h.dst_x     = COORD_W'(DX);
      h.dst_y     = COORD_W'(DY);
      h.src_x     = COORD_W'(SX);
      h.src_y     = COORD_W'(SY);
      h.fbits     = FBITS_W'(FB);
      h.msg_type  = STORE_MEM;
      h.msg_len   = MSG_LEN_W'(nf);
      h.addr      = addr;
      h.data_size = size;
      exp_q.push_back(h);
      bus.src_wr_mem_req_entry.addr = addr;
      bus.src_wr_mem_req_entry.size = size;
      bus.src_wr_mem_req_val        = 1'b1;
      t = 0;
      do begin smp(); t++; end while (!bus.wr_mem_src_req_rdy && t < 200);
      chk("req_accept", bus.wr_mem_src_req_rdy, 1);
      step();
      bus.src_wr_mem_req_val = 1'b0;
      for (int i = 0; i < nf; i++) begin
         if (stall) repeat ($urandom_range(0, 2)) step();
         for (int w = 0; w < NOC_DATA_WIDTH / 32; w++) d[w*32 +: 32] = $urandom;
         exp_q.push_back(d);
         bus.src_wr_mem_req_data      = d;
         bus.src_wr_mem_req_data_last = (i == nf - 1);
         bus.src_wr_mem_req_data_val  = 1'b1;
         t = 0;
         do begin smp(); t++; end while (!bus.wr_mem_src_req_data_rdy && t < 200);
         chk("payload_accept", bus.wr_mem_src_req_data_rdy, 1);
         step();
         bus.src_wr_mem_req_data_val  = 1'b0;
         bus.src_wr_mem_req_data_last = 1'b0;
      end
   endtask

   task automatic ack(input noc_msg_type_e t, input bit counts);
      noc_hdr_flit h;
      h          = '0;
      h.msg_type = t;
      h.dst_x    = COORD_W'(SX);
      h.dst_y    = COORD_W'(SY);
      h.src_x    = COORD_W'(DX);
      h.src_y    = COORD_W'(DY);
      if (counts) exp_done.push_back(1);
      bus.noc_wr_mem_resp_noc0_data = h;
      bus.noc_wr_mem_resp_noc0_val  = 1'b1;
      step();
      bus.noc_wr_mem_resp_noc0_val  = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin step(); t++; end
      chk("drain", exp_q.size(), 0);
   endtask

   initial begin
      int base;
      bus.src_wr_mem_req_val           = 1'b0;
      bus.src_wr_mem_req_entry         = '0;
      bus.src_wr_mem_req_data_val      = 1'b0;
      bus.src_wr_mem_req_data          = '0;
      bus.src_wr_mem_req_data_last     = 1'b0;
      bus.src_wr_mem_req_data_padbytes = '0;
      bus.noc_wr_mem_resp_noc0_val     = 1'b0;
      bus.noc_wr_mem_resp_noc0_data    = '0;
      bus.wr_req_done_rdy              = 1'b0;

      // Reset state
      repeat (3) step();
      smp();
      chk("rst_req_val", bus.wr_mem_noc_req_noc0_val, 0);
      chk("rst_done", bus.wr_req_done, 0);
      step();
      rst = 1'b0;
      step();
      step();
      smp();
      chk("rst_src_rdy", bus.wr_mem_src_req_rdy, 1);
      chk("rst_resp_rdy", bus.wr_mem_noc_resp_noc0_rdy, 1);
      chk("rst_outstanding", bus.wr_outstanding, 0);
      chk("rst_idle", bus.wr_idle, 1);
      chk("rst_err", bus.wr_err, 0);
      step();

      // 128-byte write: header msg_len 2, two payload flits, ack -> done one cycle later
      send_req(40'h00_0000_1000, 16'd128, 1'b0);
      drain();
      chk("t1_flit_count", n_flits_seen, 3);
      smp();
      chk("t1_outstanding", bus.wr_outstanding, 1);
      chk("t1_not_idle", bus.wr_idle, 0);
      repeat (4) step();
      smp();
      chk("t1_done_before_ack", bus.wr_req_done, 0);
      step();
      ack(STORE_MEM_ACK, 1'b1);
      smp();
      chk("t1_done_after_ack", bus.wr_req_done, 1);
      chk("t1_outstanding_done", bus.wr_outstanding, 1);
      step();
      bus.wr_req_done_rdy = 1'b1;
      step();
      bus.wr_req_done_rdy = 1'b0;
      smp();
      chk("t1_done_cleared", bus.wr_req_done, 0);
      chk("t1_idle", bus.wr_idle, 1);
      step();

      // Sizes 65 and 0: msg_len 2 and 0; header-only write still yields a done
      base = n_done_hs;
      send_req(40'h00_0000_2000, 16'd65, 1'b0);
      send_req(40'h00_0000_2040, 16'd0, 1'b0);
      drain();
      smp();
      chk("t2_outstanding", bus.wr_outstanding, 2);
      step();
      ack(STORE_MEM_ACK, 1'b1);
      ack(STORE_MEM_ACK, 1'b1);
      bus.wr_req_done_rdy = 1'b1;
      repeat (4) step();
      bus.wr_req_done_rdy = 1'b0;
      chk("t2_done_count", n_done_hs - base, 2);
      smp();
      chk("t2_idle", bus.wr_idle, 1);
      step();

      // Admission limit: four writes without acks close src_req_rdy
      for (int i = 0; i < MAXO; i++) send_req(40'h00_0001_0000 + 40'(i * 64), 16'd64, 1'b0);
      drain();
      smp();
      chk("t3_rdy_blocked", bus.wr_mem_src_req_rdy, 0);
      chk("t3_outstanding", bus.wr_outstanding, 4);
      step();
      ack(STORE_MEM_ACK, 1'b1);
      smp();
      chk("t3_rdy_after_ack", bus.wr_mem_src_req_rdy, 0);
      step();
      bus.wr_req_done_rdy = 1'b1;
      step();
      bus.wr_req_done_rdy = 1'b0;
      smp();
      chk("t3_rdy_reopened", bus.wr_mem_src_req_rdy, 1);
      step();

      // Done tokens held back: three acks, admission counts them, then three handshakes
      ack(STORE_MEM_ACK, 1'b1);
      ack(STORE_MEM_ACK, 1'b1);
      ack(STORE_MEM_ACK, 1'b1);
      smp();
      chk("t4_outstanding", bus.wr_outstanding, 3);
      chk("t4_done", bus.wr_req_done, 1);
      chk("t4_rdy", bus.wr_mem_src_req_rdy, 1);
      step();
      send_req(40'h00_0002_0000, 16'd64, 1'b0);
      drain();
      smp();
      chk("t4_rdy_limited", bus.wr_mem_src_req_rdy, 0);
      step();
      base = n_done_hs;
      bus.wr_req_done_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("t4_done_run", bus.wr_req_done, 1);
         step();
      end
      smp();
      chk("t4_done_end", bus.wr_req_done, 0);
      chk("t4_done_count", n_done_hs - base, 3);
      chk("t4_outstanding_left", bus.wr_outstanding, 1);
      step();
      bus.wr_req_done_rdy = 1'b0;
      ack(STORE_MEM_ACK, 1'b1);
      bus.wr_req_done_rdy = 1'b1;
      step();
      bus.wr_req_done_rdy = 1'b0;
      smp();
      chk("t4_idle", bus.wr_idle, 1);
      step();

      // Random NoC-ready and data-valid stalls on a 4-flit write
      base = n_flits_seen;
      rand_rdy = 1'b1;
      send_req(40'h00_0003_0000, 16'd256, 1'b1);
      drain();
      rand_rdy = 1'b0;
      step();
      chk("t5_flit_count", n_flits_seen - base, 5);
      ack(STORE_MEM_ACK, 1'b1);
      bus.wr_req_done_rdy = 1'b1;
      step();
      bus.wr_req_done_rdy = 1'b0;
      smp();
      chk("t5_outstanding", bus.wr_outstanding, 0);
      step();

`ifdef WR_MEM_PIPE_ERR_CHK_EN
      // Wrong ack type and ack-with-nothing-issued: sticky error, counters untouched
      ack(LOAD_MEM_ACK, 1'b0);
      smp();
      chk("t6_err_set", bus.wr_err, 1);
      chk("t6_outstanding", bus.wr_outstanding, 0);
      step();
      ack(STORE_MEM_ACK, 1'b0);
      smp();
      chk("t6_underflow_guard", bus.wr_outstanding, 0);
      chk("t6_no_done", bus.wr_req_done, 0);
      repeat (3) step();
      smp();
      chk("t6_err_sticky", bus.wr_err, 1);
      step();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      repeat (2) step();
      smp();
      chk("t6_err_cleared", bus.wr_err, 0);
      chk("t6_src_rdy", bus.wr_mem_src_req_rdy, 1);
`else
      smp();
      chk("t6_err_tied", bus.wr_err, 0);
`endif

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
